// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants for the CPU/MEM bridge and its MMIO page
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_TXSTAT = 8'h0C;
    localparam logic [7:0] OFF_CYCLO  = 8'h10;
    localparam logic [7:0] OFF_CYCHI  = 8'h14;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    localparam int TXSTAT_FULL    = 0;
    localparam int TXSTAT_EMPTY   = 1;
    localparam int TXSTAT_OVF     = 2;
    localparam int TXSTAT_CNT_LSB = 8;

    function automatic logic mmio_hit(input logic [31:0] addr);
        return addr[31:8] == MMIO_BASE[31:8];
    endfunction

endpackage

// File: rtl/mmio_bridge_tx_fifo.sv
// rtl/mmio_bridge_tx_fifo.sv - byte FIFO behind the TXDATA register with sticky overflow
module tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [7:0]                  wdata,
    input  logic                        pop,
    input  logic                        ovf_clr,
    output logic [7:0]                  rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(TX_DEPTH):0]   count,
    output logic                        overflow
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(TX_DEPTH);

    logic [7:0]    mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign full    = count == DEPTH_C;
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU/MEM data bridge with MMIO page; MMIO_CYCLE_COUNTER_EN adds the 64-bit cycle counter
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [2:0]  dm_type,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic [15:0] led,
    input  logic [15:0] sw,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic          hit;
    logic          wr;
    logic [5:0]    word;
    logic          sel_led, sel_sw, sel_txdata, sel_txstat, sel_cyclo, sel_cychi;
    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic [31:0]   txstat;
    logic [63:0]   cycles;
    logic [31:0]   mmio_rdata;

    assign hit  = mmio_hit(mem_addr);
    assign wr   = hit && mem_we;
    assign word = mem_addr[7:2];

    assign sel_led    = word == OFF_LED[7:2];
    assign sel_sw     = word == OFF_SW[7:2];
    assign sel_txdata = word == OFF_TXDATA[7:2];
    assign sel_txstat = word == OFF_TXSTAT[7:2];
    assign sel_cyclo  = word == OFF_CYCLO[7:2];
    assign sel_cychi  = word == OFF_CYCHI[7:2];

    // MEM still sees the address/data of MMIO accesses but is never written by them.
    assign dm_addr  = mem_addr;
    assign dm_type  = mem_type;
    assign dm_din   = mem_din;
    assign dm_we    = mem_we && !hit;
    assign mem_dout = hit ? mmio_rdata : dm_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            led     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (wr && sel_led) begin
                led <= mem_din[15:0];
            end
        end
    end

    tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr && sel_txdata),
        .wdata    (mem_din[7:0]),
        .pop      (tx_valid && tx_ready),
        .ovf_clr  (wr && sel_txstat && mem_din[TXSTAT_OVF]),
        .rdata    (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    assign tx_valid = !fifo_empty;

    always_comb begin
        txstat                            = '0;
        txstat[TXSTAT_FULL]               = fifo_full;
        txstat[TXSTAT_EMPTY]              = fifo_empty;
        txstat[TXSTAT_OVF]                = fifo_ovf;
        txstat[TXSTAT_CNT_LSB +: CW]      = fifo_count;
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst || (wr && sel_cyclo)) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 64'd1;
        end
    end
`else
    assign cycles = '0;
`endif

    always_comb begin
        mmio_rdata = '0;
        if (sel_led) begin
            mmio_rdata = {16'b0, led};
        end else if (sel_sw) begin
            mmio_rdata = {16'b0, sw_sync};
        end else if (sel_txstat) begin
            mmio_rdata = txstat;
        end else if (sel_cyclo) begin
            mmio_rdata = cycles[31:0];
        end else if (sel_cychi) begin
            mmio_rdata = cycles[63:32];
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - vector table plus TX scoreboard for mmio_bridge
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int TX_DEPTH = 8;
`ifdef MMIO_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_SW     = 32'hFFFF_0004;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_000C;
    localparam logic [31:0] A_CYCLO  = 32'hFFFF_0010;
    localparam logic [31:0] A_CYCHI  = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [15:0] led, sw;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int checks = 0;
    int failures = 0;
    logic [7:0]  sb [$];
    logic [31:0] ram [16];

    always #5 clk = ~clk;

    mmio_bridge #(.TX_DEPTH(TX_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_type(mem_type),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_type(dm_type),
        .dm_din(dm_din), .dm_dout(dm_dout),
        .led(led), .sw(sw),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // Small word RAM standing in for MEM; preloaded with a recognisable pattern on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        end else if (dm_we) begin
            ram[dm_addr[5:2]] <= dm_din;
        end
    end
    assign dm_dout = ram[dm_addr[5:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [2:0] t);
        mem_addr = a;
        mem_we   = we;
        mem_din  = d;
        mem_type = t;
        if (we && a == A_TXDATA) begin
            if (sb.size() < TX_DEPTH || (tx_ready && sb.size() > 0)) sb.push_back(d[7:0]);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        mem_we = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%h expected=none", tx_data);
            end else begin
                check("tx_pop", {24'b0, tx_data}, {24'b0, sb.pop_front()});
            end
        end
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [31:0] din;
        logic [2:0]  typ;
        logic        chk_dout;
        logic [31:0] exp_dout;
        logic        exp_dm_we;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"sw_mem",        32'h0000_0010, 1'b1, 32'hDEAD_BEEF, MT_W,  1'b0, 32'h0,          1'b1, 16'h0000};
        vecs[1]  = '{"lw_mem",        32'h0000_0010, 1'b0, 32'h0,         MT_W,  1'b1, 32'hDEAD_BEEF,  1'b0, 16'h0000};
        vecs[2]  = '{"sw_led",        A_LED,         1'b1, 32'h1234_ABCD, MT_W,  1'b0, 32'h0,          1'b0, 16'h0000};
        vecs[3]  = '{"lw_led",        A_LED,         1'b0, 32'h0,         MT_W,  1'b1, 32'h0000_ABCD,  1'b0, 16'hABCD};
        vecs[4]  = '{"lw_mem0_bu",    32'h0000_0000, 1'b0, 32'h0,         MT_BU, 1'b1, 32'hA500_0000,  1'b0, 16'hABCD};
        vecs[5]  = '{"lw_sw",         A_SW,          1'b0, 32'h0,         MT_W,  1'b1, 32'h0,          1'b0, 16'hABCD};
        vecs[6]  = '{"lw_txdata",     A_TXDATA,      1'b0, 32'h0,         MT_W,  1'b1, 32'h0,          1'b0, 16'hABCD};
        vecs[7]  = '{"lw_txstat",     A_TXSTAT,      1'b0, 32'h0,         MT_W,  1'b1, 32'h0000_0002,  1'b0, 16'hABCD};
        vecs[8]  = '{"sw_unmapped",   32'hFFFF_0020, 1'b1, 32'hFFFF_FFFF, MT_W,  1'b0, 32'h0,          1'b0, 16'hABCD};
        vecs[9]  = '{"lw_unmapped",   32'hFFFF_0020, 1'b0, 32'h0,         MT_W,  1'b1, 32'h0,          1'b0, 16'hABCD};
        vecs[10] = '{"lw_led_again",  A_LED,         1'b0, 32'h0,         MT_W,  1'b1, 32'h0000_ABCD,  1'b0, 16'hABCD};
        vecs[11] = '{"lw_cychi",      A_CYCHI,       1'b0, 32'h0,         MT_W,  1'b1, 32'h0,          1'b0, 16'hABCD};
        vecs[12] = '{"sb_led_unalig", 32'hFFFF_0003, 1'b1, 32'h0000_1111, MT_B,  1'b0, 32'h0,          1'b0, 16'hABCD};
        vecs[13] = '{"lh_led_unalig", 32'hFFFF_0001, 1'b0, 32'h0,         MT_H,  1'b1, 32'h0000_1111,  1'b0, 16'h1111};

        rst = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_din = '0; mem_type = MT_W;
        sw = '0; tx_ready = 1'b0;
        step();

        // Reset state and cycle counter, counted from cycle 0.
        do_reset();
        bus(A_TXSTAT, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_txstat", mem_dout, 32'h0000_0002);
        bus(A_CYCLO, 1'b0, 32'h0, MT_W);
        repeat (100) step();
        @(negedge clk);
        check("cyclo_100", mem_dout, CNT_EN ? 32'd100 : 32'd0);
        step();
        bus(A_CYCLO, 1'b1, 32'h0, MT_W);
        step();
        bus(A_CYCLO, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("cyclo_clr0", mem_dout, 32'd0);
        step();
        @(negedge clk);
        check("cyclo_clr1", mem_dout, CNT_EN ? 32'd1 : 32'd0);
        step();

        // Decode / pass-through vector table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].typ);
            @(negedge clk);
            if (vecs[i].chk_dout) check({vecs[i].name, "_dout"}, mem_dout, vecs[i].exp_dout);
            check({vecs[i].name, "_dm_we"}, {31'b0, dm_we}, {31'b0, vecs[i].exp_dm_we});
            check({vecs[i].name, "_led"}, {16'b0, led}, {16'b0, vecs[i].exp_led});
            check({vecs[i].name, "_mirror"}, {dm_type, dm_addr ^ dm_din},
                  {vecs[i].typ, vecs[i].addr ^ vecs[i].din});
            step();
        end

        // FIFO ordering.
        do_reset();
        bus(A_TXDATA, 1'b1, 32'h41, MT_W); step();
        bus(A_TXDATA, 1'b1, 32'h42, MT_W); step();
        bus(A_TXDATA, 1'b1, 32'h43, MT_W); step();
        bus(A_TXSTAT, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("fifo3_txstat", mem_dout, 32'h0000_0300);
        check("fifo3_valid", {31'b0, tx_valid}, 32'h1);
        check("fifo3_head", {24'b0, tx_data}, 32'h41);
        step();
        tx_ready = 1'b1;
        @(negedge clk); check("drain_b0", {24'b0, tx_data}, 32'h41); step();
        @(negedge clk); check("drain_b1", {24'b0, tx_data}, 32'h42); step();
        @(negedge clk); check("drain_b2", {24'b0, tx_data}, 32'h43); step();
        @(negedge clk);
        check("drain_empty_valid", {31'b0, tx_valid}, 32'h0);
        check("drain_empty_txstat", mem_dout, 32'h0000_0002);
        step();

        // Overflow, sticky clear, push-while-full with pop.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus(A_TXDATA, 1'b1, 32'h50 + 32'(i), MT_W);
            step();
        end
        bus(A_TXSTAT, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("ovf_txstat", mem_dout, 32'h0000_0805);
        step();
        bus(A_TXSTAT, 1'b1, 32'h0000_0004, MT_W);
        step();
        bus(A_TXSTAT, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("ovf_cleared", mem_dout, 32'h0000_0801);
        step();
        tx_ready = 1'b1;
        bus(A_TXDATA, 1'b1, 32'h60, MT_W);
        step();
        bus(A_TXSTAT, 1'b0, 32'h0, MT_W);
        @(negedge clk);
        check("full_push_pop", mem_dout, 32'h0000_0801);
        repeat (10) step();
        @(negedge clk);
        check("ovf_drained", mem_dout, 32'h0000_0002);
        check("sb_drained", sb.size(), 32'd0);
        step();

        // Reset with bytes queued.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus(A_TXDATA, 1'b1, 32'hA0 + 32'(i), MT_W);
            step();
        end
        bus(A_LED, 1'b1, 32'h0000_55AA, MT_W);
        step();
        mem_we = 1'b0;
        @(negedge clk);
        check("pre_rst_led", {16'b0, led}, 32'h0000_55AA);
        check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        step();
        do_reset();
        @(negedge clk);
        check("post_rst_valid", {31'b0, tx_valid}, 32'h0);
        check("post_rst_led", {16'b0, led}, 32'h0);
        check("post_rst_data", {24'b0, tx_data}, 32'h0);
        step();

        // Switch synchroniser latency.
        bus(A_SW, 1'b0, 32'h0, MT_W);
        sw = 16'h00F0;
        @(negedge clk); check("sw_edge0", mem_dout, 32'h0); step();
        @(negedge clk); check("sw_edge1", mem_dout, 32'h0); step();
        @(negedge clk); check("sw_edge2", mem_dout, 32'h0000_00F0); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
